// File: rtl/decode_stage.sv
// ID stage: register file, control decode, sign extension, load-use hazard detect, ID/EX register.
// Latency: one cycle from if_id to id_ex_*; pc_write/if_id_write are combinational.
// Backpressure: a load-use hazard drops pc_write/if_id_write for one cycle and loads a bubble; flush overrides.
module decode_stage #(
   parameter bit LOAD_USE_STALL = 1'b1,
   parameter bit WB_BYPASS      = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] if_id,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_write_reg,
   input  logic [31:0] wb_write_data,
   input  logic        flush,
   output logic [1:0]  id_ex_wb,
   output logic [2:0]  id_ex_m,
   output logic [3:0]  id_ex_ex,
   output logic [31:0] id_ex_pc_plus4,
   output logic [31:0] id_ex_reg_data1,
   output logic [31:0] id_ex_reg_data2,
   output logic [31:0] id_ex_sign_ext,
   output logic [4:0]  id_ex_rs,
   output logic [4:0]  id_ex_rt,
   output logic [4:0]  id_ex_rd,
   output logic        pc_write,
   output logic        if_id_write
);

   logic [31:0] pc_plus4;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] sign_ext;

   assign pc_plus4 = if_id[63:32];
   assign instr    = if_id[31:0];
   assign opcode   = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign sign_ext = {{16{instr[15]}}, instr[15:0]};

   logic [31:0] regs [32];
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        wb_active;

   // $0 is never written, so only a real destination counts as a write
   assign wb_active = wb_reg_write && (wb_write_reg != 5'd0);

   // Register file write port; reset wins over a same-cycle WB write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_active) begin
         regs[wb_write_reg] <= wb_write_data;
      end
   end

   // rs read port: $0 reads zero, optional write-through of the WB value
   always_comb begin
      rs_data = regs[rs];
      if (rs == 5'd0)
         rs_data = '0;
      else if (WB_BYPASS && wb_active && (wb_write_reg == rs))
         rs_data = wb_write_data;
   end

   // rt read port: same rules as rs
   always_comb begin
      rt_data = regs[rt];
      if (rt == 5'd0)
         rt_data = '0;
      else if (WB_BYPASS && wb_active && (wb_write_reg == rt))
         rt_data = wb_write_data;
   end

   logic [1:0] dec_wb;
   logic [2:0] dec_m;
   logic [3:0] dec_ex;

   // Main control decode; unknown opcodes decode to a nop
   always_comb begin
      dec_wb = 2'b00;
      dec_m  = 3'b000;
      dec_ex = 4'b0000;
      case (opcode)
         6'h00: begin dec_wb = 2'b10; dec_m = 3'b000; dec_ex = 4'b1010; end
         6'h23: begin dec_wb = 2'b11; dec_m = 3'b001; dec_ex = 4'b0001; end
         6'h2B: begin dec_wb = 2'b00; dec_m = 3'b010; dec_ex = 4'b0001; end
         6'h04: begin dec_wb = 2'b00; dec_m = 3'b100; dec_ex = 4'b0100; end
         6'h08: begin dec_wb = 2'b10; dec_m = 3'b000; dec_ex = 4'b0001; end
         default: begin dec_wb = 2'b00; dec_m = 3'b000; dec_ex = 4'b0000; end
      endcase
   end

   logic stall;
   logic bubble;

   // A load in EX whose destination feeds this instruction must wait one cycle
   assign stall = LOAD_USE_STALL && id_ex_m[0] && (id_ex_rt != 5'd0) &&
                  ((id_ex_rt == rs) || (id_ex_rt == rt));
   assign bubble      = flush || stall;
   assign pc_write    = !stall || flush;
   assign if_id_write = !stall || flush;

   // ID/EX pipeline register; a bubble zeroes control only, data loads as usual
   always_ff @(posedge clk) begin
      if (reset) begin
         id_ex_wb        <= '0;
         id_ex_m         <= '0;
         id_ex_ex        <= '0;
         id_ex_pc_plus4  <= '0;
         id_ex_reg_data1 <= '0;
         id_ex_reg_data2 <= '0;
         id_ex_sign_ext  <= '0;
         id_ex_rs        <= '0;
         id_ex_rt        <= '0;
         id_ex_rd        <= '0;
      end else begin
         id_ex_wb        <= bubble ? 2'b00   : dec_wb;
         id_ex_m         <= bubble ? 3'b000  : dec_m;
         id_ex_ex        <= bubble ? 4'b0000 : dec_ex;
         id_ex_pc_plus4  <= pc_plus4;
         id_ex_reg_data1 <= rs_data;
         id_ex_reg_data2 <= rt_data;
         id_ex_sign_ext  <= sign_ext;
         id_ex_rs        <= rs;
         id_ex_rt        <= rt;
         id_ex_rd        <= rd;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table followed by randomized cycles against a reference model.
// Each step drives inputs after a rising edge, checks pc_write before the next edge, then ID/EX after it.
// The random phase biases register indices low so load-use hazards occur frequently.
module tb_decode_stage;

   logic        clk;
   logic        reset;
   logic [63:0] if_id;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic        flush;
   logic [1:0]  id_ex_wb;
   logic [2:0]  id_ex_m;
   logic [3:0]  id_ex_ex;
   logic [31:0] id_ex_pc_plus4;
   logic [31:0] id_ex_reg_data1;
   logic [31:0] id_ex_reg_data2;
   logic [31:0] id_ex_sign_ext;
   logic [4:0]  id_ex_rs;
   logic [4:0]  id_ex_rt;
   logic [4:0]  id_ex_rd;
   logic        pc_write;
   logic        if_id_write;

   decode_stage #(.LOAD_USE_STALL(1'b1), .WB_BYPASS(1'b1)) dut (
      .clk(clk), .reset(reset), .if_id(if_id),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
      .flush(flush),
      .id_ex_wb(id_ex_wb), .id_ex_m(id_ex_m), .id_ex_ex(id_ex_ex),
      .id_ex_pc_plus4(id_ex_pc_plus4), .id_ex_reg_data1(id_ex_reg_data1),
      .id_ex_reg_data2(id_ex_reg_data2), .id_ex_sign_ext(id_ex_sign_ext),
      .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
      .pc_write(pc_write), .if_id_write(if_id_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [63:0] ifid;
      logic        wbw;
      logic [4:0]  wbr;
      logic [31:0] wbd;
      logic        fl;
      logic        pcw;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] se;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] pc;
   } vec_t;

   function automatic vec_t mkv(
      input logic rst, input logic [31:0] pc4, input logic [31:0] ins,
      input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd, input logic fl,
      input logic pcw, input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] se,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc);
      vec_t v;
      v.rst = rst; v.ifid = {pc4, ins}; v.wbw = wbw; v.wbr = wbr; v.wbd = wbd; v.fl = fl;
      v.pcw = pcw; v.wb = wb; v.m = m; v.ex = ex; v.d1 = d1; v.d2 = d2; v.se = se;
      v.rs = rs; v.rt = rt; v.rd = rd; v.pc = pc;
      return v;
   endfunction

   task automatic check_outputs(input string tag, input logic [1:0] wb, input logic [2:0] m,
                                input logic [3:0] ex, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] se, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] pc);
      chk({tag, ".wb"}, {30'd0, id_ex_wb}, {30'd0, wb});
      chk({tag, ".m"}, {29'd0, id_ex_m}, {29'd0, m});
      chk({tag, ".ex"}, {28'd0, id_ex_ex}, {28'd0, ex});
      chk({tag, ".data1"}, id_ex_reg_data1, d1);
      chk({tag, ".data2"}, id_ex_reg_data2, d2);
      chk({tag, ".sign_ext"}, id_ex_sign_ext, se);
      chk({tag, ".rs"}, {27'd0, id_ex_rs}, {27'd0, rs});
      chk({tag, ".rt"}, {27'd0, id_ex_rt}, {27'd0, rt});
      chk({tag, ".rd"}, {27'd0, id_ex_rd}, {27'd0, rd});
      chk({tag, ".pc_plus4"}, id_ex_pc_plus4, pc);
   endtask

   // Reference model state
   logic [31:0] mregs [32];
   logic        prev_memread;
   logic [4:0]  prev_rt;

   function automatic logic [8:0] ctrl_of(input logic [5:0] op);
      case (op)
         6'h00:   return {2'b10, 3'b000, 4'b1010};
         6'h23:   return {2'b11, 3'b001, 4'b0001};
         6'h2B:   return {2'b00, 3'b010, 4'b0001};
         6'h04:   return {2'b00, 3'b100, 4'b0100};
         6'h08:   return {2'b10, 3'b000, 4'b0001};
         default: return 9'd0;
      endcase
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] idx, input logic w,
                                         input logic [4:0] wr, input logic [31:0] wd);
      if (idx == 5'd0) return 32'd0;
      if (w && wr == idx) return wd;
      return mregs[idx];
   endfunction

   vec_t vecs [15];

   initial begin
      //           rst  pc+4   instr         wbw wbr    wbd           fl  pcw wb     m       ex       d1            d2            se            rs     rt     rd     pc
      vecs[0]  = mkv(0, 32'd0,  32'h00000000, 1, 5'd9,  32'd5,        0, 1, 2'b10, 3'b000, 4'b1010, 32'd0,        32'd0,        32'h0,        5'd0,  5'd0,  5'd0,  32'd0);
      vecs[1]  = mkv(0, 32'd0,  32'h00000000, 1, 5'd10, 32'd7,        0, 1, 2'b10, 3'b000, 4'b1010, 32'd0,        32'd0,        32'h0,        5'd0,  5'd0,  5'd0,  32'd0);
      vecs[2]  = mkv(0, 32'd8,  32'h012A4020, 0, 5'd0,  32'd0,        0, 1, 2'b10, 3'b000, 4'b1010, 32'd5,        32'd7,        32'h00004020, 5'd9,  5'd10, 5'd8,  32'd8);
      vecs[3]  = mkv(0, 32'd12, 32'h8C22FFFC, 0, 5'd0,  32'd0,        0, 1, 2'b11, 3'b001, 4'b0001, 32'd0,        32'd0,        32'hFFFFFFFC, 5'd1,  5'd2,  5'd31, 32'd12);
      vecs[4]  = mkv(0, 32'd16, 32'h00441820, 0, 5'd0,  32'd0,        0, 0, 2'b00, 3'b000, 4'b0000, 32'd0,        32'd0,        32'h00001820, 5'd2,  5'd4,  5'd3,  32'd16);
      vecs[5]  = mkv(0, 32'd16, 32'h00441820, 0, 5'd0,  32'd0,        0, 1, 2'b10, 3'b000, 4'b1010, 32'd0,        32'd0,        32'h00001820, 5'd2,  5'd4,  5'd3,  32'd16);
      vecs[6]  = mkv(0, 32'd20, 32'h20A60001, 1, 5'd5,  32'hDEADBEEF, 0, 1, 2'b10, 3'b000, 4'b0001, 32'hDEADBEEF, 32'd0,        32'h00000001, 5'd5,  5'd6,  5'd0,  32'd20);
      vecs[7]  = mkv(0, 32'd24, 32'h20070000, 1, 5'd0,  32'hFFFFFFFF, 0, 1, 2'b10, 3'b000, 4'b0001, 32'd0,        32'd0,        32'h0,        5'd0,  5'd7,  5'd0,  32'd24);
      vecs[8]  = mkv(0, 32'd28, 32'h10050003, 0, 5'd0,  32'd0,        0, 1, 2'b00, 3'b100, 4'b0100, 32'd0,        32'hDEADBEEF, 32'h00000003, 5'd0,  5'd5,  5'd0,  32'd28);
      vecs[9]  = mkv(0, 32'd32, 32'h8C280000, 0, 5'd0,  32'd0,        0, 1, 2'b11, 3'b001, 4'b0001, 32'd0,        32'd0,        32'h0,        5'd1,  5'd8,  5'd0,  32'd32);
      vecs[10] = mkv(0, 32'd36, 32'h11090004, 0, 5'd0,  32'd0,        1, 1, 2'b00, 3'b000, 4'b0000, 32'd0,        32'd5,        32'h00000004, 5'd8,  5'd9,  5'd0,  32'd36);
      vecs[11] = mkv(0, 32'd40, 32'h8C250000, 0, 5'd0,  32'd0,        0, 1, 2'b11, 3'b001, 4'b0001, 32'd0,        32'hDEADBEEF, 32'h0,        5'd1,  5'd5,  5'd0,  32'd40);
      vecs[12] = mkv(1, 32'd44, 32'h20A60001, 1, 5'd9,  32'h00001234, 0, 0, 2'b00, 3'b000, 4'b0000, 32'd0,        32'd0,        32'h0,        5'd0,  5'd0,  5'd0,  32'd0);
      vecs[13] = mkv(0, 32'd44, 32'h20A60001, 0, 5'd0,  32'd0,        0, 1, 2'b10, 3'b000, 4'b0001, 32'd0,        32'd0,        32'h00000001, 5'd5,  5'd6,  5'd0,  32'd44);
      vecs[14] = mkv(0, 32'd8,  32'h012A4020, 0, 5'd0,  32'd0,        0, 1, 2'b10, 3'b000, 4'b1010, 32'd0,        32'd0,        32'h00004020, 5'd9,  5'd10, 5'd8,  32'd8);

      // Power-on reset
      reset = 1'b1; if_id = '0; wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0; flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset", 2'b00, 3'b000, 4'b0000, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      reset = 1'b0;
      #1;
      chk("reset.pc_write", {31'd0, pc_write}, 32'd1);
      chk("reset.if_id_write", {31'd0, if_id_write}, 32'd1);

      // Directed vector table
      for (int i = 0; i < 15; i++) begin
         reset = vecs[i].rst; if_id = vecs[i].ifid; wb_reg_write = vecs[i].wbw;
         wb_write_reg = vecs[i].wbr; wb_write_data = vecs[i].wbd; flush = vecs[i].fl;
         #1;
         chk($sformatf("vec%0d.pc_write", i), {31'd0, pc_write}, {31'd0, vecs[i].pcw});
         chk($sformatf("vec%0d.if_id_write", i), {31'd0, if_id_write}, {31'd0, vecs[i].pcw});
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].wb, vecs[i].m, vecs[i].ex, vecs[i].d1,
                       vecs[i].d2, vecs[i].se, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].pc);
      end

      // Randomized phase against the reference model; cycle 0 forces a reset
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      prev_memread = 1'b0;
      prev_rt = 5'd0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         logic [5:0]  op;
         logic [4:0]  r_s, r_t;
         logic [15:0] imm;
         logic [31:0] pc4, ins;
         logic        rst_i, wbw_i, fl_i, stl;
         logic [4:0]  wbr_i;
         logic [31:0] wbd_i;
         logic [8:0]  c;
         logic [1:0]  e_wb;
         logic [2:0]  e_m;
         logic [3:0]  e_ex;
         logic [31:0] e_d1, e_d2, e_se, e_pc;
         logic [4:0]  e_rs, e_rt, e_rd;
         case ($urandom_range(0, 5))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            4: op = 6'h08;
            default: op = 6'($urandom_range(0, 63));
         endcase
         r_s   = 5'($urandom_range(0, 7));
         r_t   = 5'($urandom_range(0, 7));
         imm   = 16'($urandom);
         pc4   = $urandom;
         ins   = {op, r_s, r_t, imm};
         rst_i = (cyc == 0) || ($urandom_range(0, 59) == 0);
         wbw_i = 1'($urandom_range(0, 1));
         wbr_i = 5'($urandom_range(0, 7));
         wbd_i = $urandom;
         fl_i  = ($urandom_range(0, 7) == 0);

         reset = rst_i; if_id = {pc4, ins}; wb_reg_write = wbw_i;
         wb_write_reg = wbr_i; wb_write_data = wbd_i; flush = fl_i;
         #1;
         stl = prev_memread && prev_rt != 5'd0 && (prev_rt == r_s || prev_rt == r_t);
         if (cyc > 0) begin
            chk($sformatf("rnd%0d.pc_write", cyc), {31'd0, pc_write}, {31'd0, (!stl || fl_i)});
            chk($sformatf("rnd%0d.if_id_write", cyc), {31'd0, if_id_write}, {31'd0, (!stl || fl_i)});
         end

         if (rst_i) begin
            {e_wb, e_m, e_ex} = 9'd0;
            e_d1 = 0; e_d2 = 0; e_se = 0; e_pc = 0; e_rs = 0; e_rt = 0; e_rd = 0;
            for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
         end else begin
            c = (fl_i || stl) ? 9'd0 : ctrl_of(op);
            {e_wb, e_m, e_ex} = c;
            e_d1 = mread(r_s, wbw_i, wbr_i, wbd_i);
            e_d2 = mread(r_t, wbw_i, wbr_i, wbd_i);
            e_se = {{16{imm[15]}}, imm};
            e_pc = pc4;
            e_rs = r_s; e_rt = r_t; e_rd = imm[15:11];
            if (wbw_i && wbr_i != 5'd0) mregs[wbr_i] = wbd_i;
         end
         prev_memread = e_m[0];
         prev_rt = e_rt;

         @(posedge clk);
         #1;
         check_outputs($sformatf("rnd%0d", cyc), e_wb, e_m, e_ex, e_d1, e_d2, e_se, e_rs, e_rt, e_rd, e_pc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS pipeline.
- Consumes the 64-bit IF/ID word produced by fetch: [63:32] = PC+4, [31:0] = instruction.
- Owns the 32x32 register file, the main control decode, sign extension, load-use hazard detection and the ID/EX pipeline register.
- Its outputs drive the execute stage inputs directly. It receives register writes back from the WB stage.

Parameters:
- LOAD_USE_STALL, 1, 1 = load-use hazard detection enabled; 0 = pc_write and if_id_write tied high.
- WB_BYPASS, 1, 1 = a register write in the same cycle as a read returns the new data (write-through); 0 = returns old data.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_id  in  64  {PC+4, instruction} from fetch
- wb_reg_write  in  1  WB-stage RegWrite
- wb_write_reg  in  5  WB destination register
- wb_write_data  in  32  WB write data
- flush  in  1  branch taken in MEM (PCSrc); squash the instruction in ID
- id_ex_wb  out  2  [1]=RegWrite, [0]=MemtoReg
- id_ex_m  out  3  [2]=Branch, [1]=MemWrite, [0]=MemRead
- id_ex_ex  out  4  [3:2]=ALUOp, [1]=RegDst (1 selects rd), [0]=ALUSrc (1 selects immediate)
- id_ex_pc_plus4  out  32  registered PC+4
- id_ex_reg_data1  out  32  registered rs value
- id_ex_reg_data2  out  32  registered rt value
- id_ex_sign_ext  out  32  registered sign-extended imm[15:0]
- id_ex_rs  out  5  registered instr[25:21], for forwarding
- id_ex_rt  out  5  registered instr[20:16]
- id_ex_rd  out  5  registered instr[15:11]
- pc_write  out  1  combinational; 0 = fetch holds PC
- if_id_write  out  1  combinational; 0 = fetch holds IF/ID

Behaviour:
- Reset (synchronous, on the clk edge with reset=1):
  - All id_ex_* outputs clear to 0.
  - All 32 registers clear to 0.
  - Reset beats a simultaneous WB write.
  - If reset is asserted mid-stall, the stall clears on the next cycle because id_ex_m[0] becomes 0.
- Register file:
  - Write on the rising edge when wb_reg_write=1 and wb_write_reg!=0.
  - Register $0 always reads 0, and writes to it are ignored.
  - Reads are combinational on rs/rt.
  - With WB_BYPASS=1: if wb_reg_write=1, wb_write_reg is nonzero and equals the read index, the read returns wb_write_data in the same cycle.
- Control decode on opcode instr[31:26], given as WB/M/EX:
  - 0x00 R-type: WB=10, M=000, EX=1010.
  - 0x23 lw: WB=11, M=001, EX=0001.
  - 0x2B sw: WB=00, M=010, EX=0001.
  - 0x04 beq: WB=00, M=100, EX=0100.
  - 0x08 addi: WB=10, M=000, EX=0001.
  - Any other opcode: all control bits 0 (treated as nop).
- Sign extension: id_ex_sign_ext = {16{instr[15]}, instr[15:0]}. The funct field reaches ALU control through bits [5:0].
- Hazard detection (LOAD_USE_STALL=1):
  - stall = id_ex_m[0] && id_ex_rt!=0 && (id_ex_rt==instr[25:21] || id_ex_rt==instr[20:16]).
  - pc_write = if_id_write = !stall || flush.
- ID/EX register update on each rising edge, unless reset:
  - If flush or stall: load a bubble. id_ex_wb, id_ex_m and id_ex_ex become 0. Data and index fields load normally; they are don't-care but must be deterministic.
  - Otherwise: load the decoded control and data.
- Latency: one cycle from if_id to id_ex_*.
- A load-use pair costs exactly one bubble. On the next cycle id_ex_m[0]=0, so the stall drops.
- If flush and stall are both asserted, flush wins: bubble inserted, pc_write=1.
- The register file is written regardless of stall or flush.

Test Plan:
- Reset, then if_id={32'd8, 32'h012A4020} (add $8,$9,$10) with $9=5 and $10=7 preloaded via WB → next cycle: id_ex_reg_data1=5, id_ex_reg_data2=7, id_ex_wb=10, id_ex_m=000, id_ex_ex=1010, id_ex_rd=8, id_ex_pc_plus4=8.
- lw $2,-4($1), encoded 32'h8C22FFFC → id_ex_sign_ext=32'hFFFFFFFC, id_ex_wb=11, id_ex_m=001, id_ex_ex=0001, id_ex_rt=2.
- lw $2,0($1) followed by add $3,$2,$4 → for one cycle pc_write=if_id_write=0 and a bubble is loaded (id_ex_wb/m/ex=0); the following cycle the add issues with pc_write=1.
- WB writes $5=32'hDEADBEEF in the same cycle that ID reads rs=$5 → id_ex_reg_data1=32'hDEADBEEF next cycle. Write to $0 → reads of $0 stay 0.
- flush=1 with a valid beq in ID, and simultaneously a load-use stall → bubble loaded, pc_write=1.
- Assert reset during a stall with nonzero registers → all outputs 0, all registers read 0, pc_write=1 on the following cycle.
